floating_point_delay_line: RTL and testbench
============================================

Name: floating_point_delay_line

Overview:
- Parametrised, multi-channel latency-matching buffer for floating-point streams.
- Carries NUM_CH packed FP words alongside an FP arithmetic unit so side streams arrive aligned with its results.
- Latency is selectable at runtime between a full-pipeline depth and a save-FF depth.
- Adds stall, flush, a drain-then-switch mode change and an occupancy counter.

Parameters:
- EXP_WIDTH, 8, exponent width of each FP word.
- FRAC_WIDTH, 23, fraction width of each FP word.
- NUM_CH, 2, number of FP words carried per beat.
- LAT_FULL, 7, latency in mode 0; also the physical shift depth.
- LAT_SAVE, 3, latency in mode 1; constraint 1 <= LAT_SAVE <= LAT_FULL.
- MODE_RESET, 0, mode loaded on reset.
- FP_WIDTH (local), 1+EXP_WIDTH+FRAC_WIDTH.
- OCC_W (local), $clog2(LAT_FULL+1).

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, synchronous active-high reset.
- fp_i, input, NUM_CH*FP_WIDTH, packed input words; channel k is at bits [k*FP_WIDTH +: FP_WIDTH].
- valid_i, input, 1, input beat valid.
- ready_o, output, 1, block accepts a beat this cycle.
- stall_i, input, 1, freezes the whole pipeline.
- flush_i, input, 1, discards all in-flight beats.
- mode_i, input, 1, requested latency mode: 0 = LAT_FULL, 1 = LAT_SAVE.
- fp_o, output, NUM_CH*FP_WIDTH, delayed words.
- valid_o, output, 1, output beat valid.
- mode_o, output, 1, mode currently in effect.
- occupancy_o, output, OCC_W, valid beats in flight within the active depth.
- busy_o, output, 1, high while in DRAIN or SWITCH.

Behaviour:
- Storage:
  - LAT_FULL data stages (no reset) and LAT_FULL valid bits (reset to 0).
  - Output tap = stage LAT_FULL-1 when mode_o=0, stage LAT_SAVE-1 when mode_o=1.
  - fp_o/valid_o come from the tap registers; no combinational path from fp_i to fp_o.
- Reset: all valid bits 0, occupancy_o=0, state=RUN, mode_o=MODE_RESET, busy_o=0, valid_o=0. Reset overrides all other inputs.
- Shift:
  - When stall_i=0 and flush_i=0, every stage advances one position each cycle.
  - Stage 0 loads fp_i; its valid bit loads (valid_i & ready_o).
  - Stages past the tap keep shifting but are never observed.
- Latency:
  - A beat accepted at edge t appears on valid_o/fp_o after L edges with no stall (L = active latency).
  - Each stalled cycle adds exactly one cycle.
- ready_o = (state==RUN) & ~stall_i & ~flush_i & (mode_i==mode_o).
- valid_o = tap_valid & ~stall_i, so a beat is presented exactly once and never during a stall. fp_o holds during a stall.
- Stall: all data and valid bits and occupancy hold; the state machine holds.
- Flush:
  - At the next edge all valid bits clear and occupancy becomes 0; data is not cleared.
  - Flush has priority over stall and over acceptance.
  - The state machine still advances: DRAIN sees occupancy 0 on the following cycle.
- Occupancy: next = current + accept - emit. accept = valid_i & ready_o; emit = valid_o. It is never negative and never exceeds the active latency.
- State machine:
  - RUN → DRAIN when mode_i != mode_o; latch the target mode (= mode_i); busy_o=1.
  - DRAIN: accepts nothing; the pipeline keeps shifting and emitting. When occupancy_o==0 (and no stall), go to SWITCH.
  - Changes on mode_i during DRAIN are ignored; the latched target is used.
  - SWITCH, one cycle: mode_o ← target; all valid bits cleared (discards stale beats past the old tap); next state RUN.
  - On entering RUN, if mode_i differs again, a new DRAIN starts the following cycle.
- Simultaneous events: rst > flush > stall > normal shift. An accept and an emit in the same cycle leave occupancy unchanged.

Test Plan:
1. Mode 0, continuous valid_i, beats with ch0=0x3F800000+n and ch1=n → each beat appears exactly 7 cycles after acceptance, in order; occupancy_o saturates at 7.
2. Reset with MODE_RESET=1, one beat 0x40490FDB → valid_o high exactly 3 cycles later with that word; occupancy goes 1,1,1 then 0.
3. Mode 0, single beat, stall_i high for 4 cycles at cycle 2 → output at cycle 11; valid_o=0 throughout the stall; occupancy held.
4. Mode 0, 5 beats in flight, flush_i one cycle → next cycle occupancy_o=0, valid_o never asserts for those beats; a beat accepted 1 cycle later emerges 7 cycles after acceptance.
5. Mode 0 with 3 beats in flight, mode_i←1 → ready_o=0, busy_o=1; the 3 beats emerge with 7-cycle latency; SWITCH then makes mode_o=1; the next accepted beat has 3-cycle latency with no stale valid_o.
6. Mode 1→0 switch with beats previously written past tap 2 → after SWITCH no spurious valid_o appears within 7 cycles; occupancy_o=0.

Source files
------------

// File: rtl/floating_point_delay_line.sv
// floating_point_delay_line
//   Latency-matching buffer that carries NUM_CH packed FP words next to an FP
//   arithmetic unit, so side streams arrive aligned with that unit's results.
//   The latency is selectable at runtime: LAT_FULL (mode 0) or LAT_SAVE (mode 1).
//   A mode change first drains the in-flight beats, then spends one cycle
//   switching the tap over.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   fp_i         NUM_CH packed FP words; channel k at [k*FP_WIDTH +: FP_WIDTH]
//   valid_i      input beat valid
//   ready_o      a beat is accepted this cycle when valid_i is also high
//   stall_i      freezes the whole pipeline, including the state machine
//   flush_i      discards every in-flight beat at the next edge
//   mode_i       requested latency mode (0 = LAT_FULL, 1 = LAT_SAVE)
//   fp_o         delayed words, taken from the active tap register
//   valid_o      output beat valid; never asserted during a stall
//   mode_o       latency mode currently in effect
//   occupancy_o  valid beats in flight within the active depth
//   busy_o       high while draining or switching mode
module floating_point_delay_line #(
    parameter int   EXP_WIDTH  = 8,
    parameter int   FRAC_WIDTH = 23,
    parameter int   NUM_CH     = 2,
    parameter int   LAT_FULL   = 7,
    parameter int   LAT_SAVE   = 3,   // must satisfy 1 <= LAT_SAVE <= LAT_FULL
    parameter logic MODE_RESET = 1'b0,
    localparam int  FP_WIDTH   = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int  OCC_W      = $clog2(LAT_FULL + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CH*FP_WIDTH-1:0] fp_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       mode_i,
    output logic [NUM_CH*FP_WIDTH-1:0] fp_o,
    output logic                       valid_o,
    output logic                       mode_o,
    output logic [OCC_W-1:0]           occupancy_o,
    output logic                       busy_o
);

    localparam int DW = NUM_CH * FP_WIDTH;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    logic [LAT_FULL-1:0][DW-1:0] r_data;
    logic [LAT_FULL-1:0]         r_vld;
    logic [1:0]                  r_state;
    logic                        r_mode;
    logic                        r_target;
    logic [OCC_W-1:0]            r_occ;

    logic w_shift;
    logic w_accept;
    logic w_tap_vld;

    // Data moves only on a plain shift cycle; a flush leaves data in place
    // because the cleared valid bits already make it invisible.
    assign w_shift   = ~stall_i & ~flush_i;
    assign ready_o   = (r_state == ST_RUN) & ~stall_i & ~flush_i & (mode_i == r_mode);
    assign w_accept  = valid_i & ready_o;
    assign w_tap_vld = r_mode ? r_vld[LAT_SAVE-1] : r_vld[LAT_FULL-1];

    // Gating with stall keeps a beat from being presented twice: the tap
    // register holds through the stall and is shown once it moves again.
    assign valid_o     = w_tap_vld & ~stall_i;
    assign fp_o        = r_mode ? r_data[LAT_SAVE-1] : r_data[LAT_FULL-1];
    assign mode_o      = r_mode;
    assign occupancy_o = r_occ;
    assign busy_o      = (r_state == ST_DRAIN) | (r_state == ST_SWITCH);

    // Data stages carry no reset.
    always_ff @(posedge clk_i) begin
        if (w_shift) begin
            r_data[0] <= fp_i;
            for (int s = 1; s < LAT_FULL; s++) begin
                r_data[s] <= r_data[s-1];
            end
        end
    end

    // Valid bits. SWITCH wipes them: in 1->0 changes, beats that ran past the
    // short tap would otherwise show up later at the long tap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= '0;
        end else if (flush_i) begin
            r_vld <= '0;
        end else if (stall_i) begin
            r_vld <= r_vld;
        end else if (r_state == ST_SWITCH) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int s = 1; s < LAT_FULL; s++) begin
                r_vld[s] <= r_vld[s-1];
            end
        end
    end

    // Occupancy: accept and emit cancel when they coincide. Both are zero
    // during a stall, so the count holds there by itself.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_occ <= '0;
        end else if (flush_i) begin
            r_occ <= '0;
        end else if (!stall_i && r_state == ST_SWITCH) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_accept) - OCC_W'(valid_o);
        end
    end

    // Mode-change state machine. A flush overrides a stall here too, so that
    // DRAIN sees the cleared occupancy on the very next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_RUN;
            r_mode   <= MODE_RESET;
            r_target <= MODE_RESET;
        end else if (stall_i && !flush_i) begin
            r_state <= r_state;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mode_i != r_mode) begin
                        r_state  <= ST_DRAIN;
                        r_target <= mode_i;  // later mode_i changes are ignored
                    end
                end
                ST_DRAIN: begin
                    if (r_occ == '0) r_state <= ST_SWITCH;
                end
                ST_SWITCH: begin
                    r_mode  <= r_target;
                    r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_delay_line.sv
module tb_floating_point_delay_line;

    localparam int LF = 7;
    localparam int LS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fp_in;
    logic        vin, stall, flush, mode_in;
    logic        rdy, vout, mode_out, busy;
    logic [63:0] fp_out;
    logic [2:0]  occ;

    // second instance, reset into mode 1
    logic [63:0] b_fp_in, b_fp_out;
    logic        b_vin, b_rdy, b_vout, b_mode, b_busy;
    logic [2:0]  b_occ;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    floating_point_delay_line #(.LAT_FULL(LF), .LAT_SAVE(LS), .MODE_RESET(1'b0)) u_dut (
        .clk_i(clk), .rst_i(rst), .fp_i(fp_in), .valid_i(vin), .ready_o(rdy),
        .stall_i(stall), .flush_i(flush), .mode_i(mode_in), .fp_o(fp_out),
        .valid_o(vout), .mode_o(mode_out), .occupancy_o(occ), .busy_o(busy)
    );

    floating_point_delay_line #(.LAT_FULL(LF), .LAT_SAVE(LS), .MODE_RESET(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .fp_i(b_fp_in), .valid_i(b_vin), .ready_o(b_rdy),
        .stall_i(1'b0), .flush_i(1'b0), .mode_i(1'b1), .fp_o(b_fp_out),
        .valid_o(b_vout), .mode_o(b_mode), .occupancy_o(b_occ), .busy_o(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int n);
        return {32'(n), 32'h3F80_0000 + 32'(n)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard for u_dut ----------------
    typedef struct {
        logic [63:0] d;
        int          due;
    } ent_t;

    ent_t q[$];
    ent_t e;
    int   sc = 0;   // count of shifting edges seen so far

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("occ", 64'(occ), 64'(q.size()));
            if (!stall && q.size() > 0 && q[0].due == sc) begin
                e = q.pop_front();
                chk("emit_valid", 64'(vout), 64'd1);
                if (vout) chk("emit_data", fp_out, e.d);
            end else if (vout) begin
                chk("spurious_valid", 64'(vout), 64'd0);
            end
            if (flush) q.delete();
            if (vin && rdy) q.push_back('{d: fp_in, due: sc + (mode_in ? LS : LF)});
            if (!stall && !flush) sc++;
        end
    end

    // ---------------- stimulus ----------------
    int nb = 0;
    int k, n, cnt;
    bit got;
    logic [2:0] exp_occ [4] = '{3'd1, 3'd1, 3'd1, 3'd0};
    logic       exp_vo  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; vin = 1'b0; stall = 1'b0; flush = 1'b0; mode_in = 1'b0;
        fp_in = '0; b_vin = 1'b0; b_fp_in = '0;
        repeat (3) tick();
        rst = 1'b0;

        // reset state of both instances, single beat into the mode-1 instance
        b_vin = 1'b1; b_fp_in = 64'h0000_0000_4049_0FDB;
        @(negedge clk);
        chk("rst_valid", 64'(vout), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_mode", 64'(mode_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(rdy), 64'd1);
        chk("b_rst_mode", 64'(b_mode), 64'd1);
        chk("b_rst_busy", 64'(b_busy), 64'd0);
        chk("b_ready", 64'(b_rdy), 64'd1);
        chk("b_rst_occ", 64'(b_occ), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            b_vin = 1'b0;
            @(negedge clk);
            chk($sformatf("b_occ%0d", i), 64'(b_occ), 64'(exp_occ[i-1]));
            chk($sformatf("b_valid%0d", i), 64'(b_vout), 64'(exp_vo[i-1]));
            if (i == 3) chk("b_data", b_fp_out, 64'h0000_0000_4049_0FDB);
        end

        // continuous stream in mode 0
        for (int i = 0; i < 20; i++) begin
            tick();
            vin = 1'b1; fp_in = mk(nb++);
            if (i == 12) begin
                @(negedge clk);
                chk("occ_sat", 64'(occ), 64'd7);
            end
        end
        tick(); vin = 1'b0;
        repeat (10) tick();

        // single beat with a 4-cycle stall starting at cycle 2
        vin = 1'b1; fp_in = mk(nb++);
        k = 0; got = 1'b0;
        while (!got && k < 30) begin
            tick();
            k++;
            vin = 1'b0;
            stall = (k >= 2 && k <= 5);
            @(negedge clk);
            if (stall) chk("stall_valid", 64'(vout), 64'd0);
            if (vout) got = 1'b1;
        end
        chk("stall_latency", 64'(k), 64'd11);
        tick(); stall = 1'b0;
        repeat (3) tick();

        // five beats in flight, then flush
        for (int i = 0; i < 5; i++) begin
            tick(); vin = 1'b1; fp_in = mk(nb++);
        end
        tick(); flush = 1'b1; fp_in = mk(nb++);
        @(negedge clk);
        chk("flush_ready", 64'(rdy), 64'd0);
        chk("flush_occ", 64'(occ), 64'd5);
        tick(); flush = 1'b0; fp_in = mk(nb++);
        @(negedge clk);
        chk("post_flush_occ", 64'(occ), 64'd0);
        chk("post_flush_ready", 64'(rdy), 64'd1);
        tick(); vin = 1'b0;
        repeat (10) tick();

        // mode 0 -> 1 with three beats in flight
        for (int i = 0; i < 3; i++) begin
            tick(); vin = 1'b1; fp_in = mk(nb++);
        end
        tick(); mode_in = 1'b1; fp_in = mk(nb++);
        @(negedge clk);
        chk("sw1_ready", 64'(rdy), 64'd0);
        tick(); fp_in = mk(nb++);
        @(negedge clk);
        chk("sw1_busy", 64'(busy), 64'd1);
        chk("sw1_ready_drain", 64'(rdy), 64'd0);
        n = 0;
        do begin
            tick(); n++; fp_in = mk(nb++);
            @(negedge clk);
        end while (busy && n < 40);
        chk("sw1_drain_len", 64'(n), 64'd8);
        chk("sw1_mode", 64'(mode_out), 64'd1);
        chk("sw1_ready_after", 64'(rdy), 64'd1);
        repeat (2) begin
            tick(); fp_in = mk(nb++);
        end
        tick(); vin = 1'b0;
        repeat (6) tick();

        // mode 1 -> 0 with beats written past the short tap
        for (int i = 0; i < 6; i++) begin
            tick(); vin = 1'b1; fp_in = mk(nb++);
        end
        tick(); vin = 1'b0; mode_in = 1'b0;
        tick();
        @(negedge clk);
        chk("sw2_busy", 64'(busy), 64'd1);
        n = 0;
        do begin
            tick(); n++;
            @(negedge clk);
        end while (busy && n < 40);
        chk("sw2_drain_len", 64'(n), 64'd4);
        chk("sw2_mode", 64'(mode_out), 64'd0);
        chk("sw2_occ", 64'(occ), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (vout) cnt++;
        end
        chk("sw2_no_stale", 64'(cnt), 64'd0);

        // random traffic, stalls, flushes and mode requests
        for (int i = 0; i < 300; i++) begin
            tick();
            vin   = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 39) == 0) mode_in = ~mode_in;
            fp_in = mk(nb++);
        end
        tick();
        vin = 1'b0; stall = 1'b0; flush = 1'b0; mode_in = 1'b0;
        repeat (40) tick();
        @(negedge clk);
        chk("end_mode", 64'(mode_out), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_occ", 64'(occ), 64'd0);
        chk("end_queue", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "timeout");
    end

endmodule
